// File: rtl/fp32_pkg.sv
// fp32_pkg: single-precision field layout and constants shared by the int<->float converters.
package fp32_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;
    localparam int EXP_BIAS       = 127;
    localparam int EXP_W          = 8;
    localparam int FRAC_W         = 23;
    localparam int INT2F_EXP_BASE = 158;
endpackage

// File: rtl/i2f_32_pipe_if.sv
// i2f_32_pipe_if: input and output valid/ready handshakes of the int->float converter.
interface i2f_32_pipe_if;
    logic        in_valid, in_ready, out_valid, out_ready, p_lost;
    logic [31:0] a, d;
    modport master (output in_valid, a, out_ready, input in_ready, out_valid, d, p_lost);
    modport slave  (input in_valid, a, out_ready, output in_ready, out_valid, d, p_lost);
endinterface

// File: rtl/lzc32.sv
// lzc32: combinational leading-zero counter; an all-zero input reports 0 with zero_o set.
module lzc32 (
    input  logic [31:0] in_i,
    output logic [4:0]  cnt_o,
    output logic        zero_o
);
    always_comb begin
        cnt_o = 5'd0;
        for (int i = 0; i < 32; i++) if (in_i[i]) cnt_o = 5'(31 - i);
    end
    assign zero_o = ~|in_i;
endmodule

// File: rtl/i2f_32_pipe.sv
// i2f_32_pipe: 3-stage elastic int32 -> fp32 converter, round-to-nearest-even.
// Optional sticky inexact flag with flag_clr/p_lost_acc when I2F_STICKY_EN is defined.
module i2f_32_pipe
    import fp32_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef I2F_STICKY_EN
    input  logic          flag_clr,
    output logic          p_lost_acc,
`endif
    i2f_32_pipe_if.slave  io
);
    logic        v1_q, v2_q, v3_q, ld1, ld2, ld3;
    logic        sign1_d, sign1_q, sign2_q, zero2_d, zero2_q, lost3_d, lost3_q;
    logic [31:0] mag1_d, mag1_q, norm2_d, norm2_q;
    logic [4:0]  lz2_d, lz2_q;
    logic [23:0] mant;
    logic        g, s, rnd;
    logic [24:0] m25;
    logic [7:0]  exp3;
    fp32_t       res3_d, res3_q;
    // A stage may load when it is empty or its contents move on this edge.
    assign ld3          = ~v3_q | io.out_ready;
    assign ld2          = ~v2_q | ld3;
    assign ld1          = ~v1_q | ld2;
    assign io.in_ready  = ld1;
    assign io.out_valid = v3_q;
    assign io.d         = res3_q;
    assign io.p_lost    = lost3_q;
    assign sign1_d = SIGNED_IN & io.a[31];
    assign mag1_d  = sign1_d ? -io.a : io.a;
    lzc32 u_lzc (.in_i(mag1_q), .cnt_o(lz2_d), .zero_o(zero2_d));
    assign norm2_d = mag1_q << lz2_d;
    assign mant    = norm2_q[31:8];
    assign g       = norm2_q[7];
    assign s       = |norm2_q[6:0];
    assign rnd     = g & (s | mant[0]);
    assign m25     = {1'b0, mant} + 25'(rnd);
    // A mantissa carry leaves m25[22:0] zero, so only the exponent needs bumping.
    assign exp3    = 8'(INT2F_EXP_BASE - int'(lz2_q) + int'(m25[24]));
    assign res3_d  = zero2_q ? '0 : {sign2_q, exp3, m25[22:0]};
    assign lost3_d = ~zero2_q & (g | s);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1_q, v2_q, v3_q}       <= '0;
            {sign1_q, sign2_q}       <= '0;
            {zero2_q, lost3_q}       <= '0;
            {mag1_q, norm2_q, lz2_q} <= '0;
            res3_q                   <= '0;
        end else begin
            if (ld1) begin
                v1_q <= io.in_valid;
                if (io.in_valid) {sign1_q, mag1_q} <= {sign1_d, mag1_d};
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) {sign2_q, zero2_q, lz2_q, norm2_q} <= {sign1_q, zero2_d, lz2_d, norm2_d};
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) {res3_q, lost3_q} <= {res3_d, lost3_d};
            end
        end
    end
`ifdef I2F_STICKY_EN
    logic p_lost_acc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_lost_acc_q <= 1'b0;
        else p_lost_acc_q <= flag_clr ? 1'b0 : p_lost_acc_q | (v3_q & io.out_ready & lost3_q);
    end
    assign p_lost_acc = p_lost_acc_q;
`endif
endmodule
